// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_TX between NREQ byte producers.
// Grants one requester per frame and follows the frame through UART_TX busy.
module uart_tx_sched #(
  parameter int WIDTH         = 8,
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]          req_par_en,
  input  logic [NREQ-1:0]          req_par_type,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          done,
  output logic                     start_err,
  output logic [$clog2(NREQ)-1:0]  active_id,
  input  logic                     tx_busy,
  output logic                     Data_Valid,
  output logic [WIDTH-1:0]         P_DATA,
  output logic                     parity_enable,
  output logic                     parity_type
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  int              scan_pos;

  // First set request at or above ptr, wrapping back to 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    scan_pos  = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_pos = int'(ptr) + k;
      if (scan_pos >= NREQ) scan_pos = scan_pos - NREQ;
      scan_idx = ID_W'(scan_pos);
      if (!grant_vld && req[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      ptr           <= '0;
      cnt           <= '0;
      ack           <= '0;
      done          <= '0;
      start_err     <= 1'b0;
      active_id     <= '0;
      Data_Valid    <= 1'b0;
      P_DATA        <= '0;
      parity_enable <= 1'b0;
      parity_type   <= 1'b0;
    end else begin
      ack        <= '0;
      done       <= '0;
      start_err  <= 1'b0;
      Data_Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_vld && !tx_busy) begin
            P_DATA        <= req_data[grant_idx*WIDTH +: WIDTH];
            parity_enable <= req_par_en[grant_idx];
            parity_type   <= req_par_type[grant_idx];
            active_id     <= grant_idx;
            ack           <= ONE_HOT0 << grant_idx;
            Data_Valid    <= 1'b1;
            ptr           <= (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + ID_W'(1);
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // Timeout fires on the cycle the incremented count would hit START_TIMEOUT-1.
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CNT_W'(START_TIMEOUT-2)) begin
            start_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            done  <= ONE_HOT0 << active_id;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched: a timeline model predicts every
// ack/done/start_err pulse, and a negedge monitor compares the DUT against it.
module tb_uart_tx_sched;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int ST    = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_par_en = '0;
  logic [3:0]  req_par_type = '0;
  logic        tx_busy = 1'b0;
  logic [3:0]  ack, done;
  logic        start_err;
  logic [1:0]  active_id;
  logic        Data_Valid;
  logic [7:0]  P_DATA;
  logic        parity_enable, parity_type;

  uart_tx_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .START_TIMEOUT(ST)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_type(req_par_type),
    .ack(ack), .done(done), .start_err(start_err), .active_id(active_id),
    .tx_busy(tx_busy), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .parity_enable(parity_enable), .parity_type(parity_type)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [8:0] vec;   // {ack, done, start_err}
    int         id;
    logic [7:0] data;
    logic       pe;
    logic       pt;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: a frame is a timeline (ack, optional busy window, done or timeout).
  int         m_ptr = 0;
  int         free_at = 0;
  int         busy_lo = -1;
  int         busy_hi = -2;
  logic       ext_busy = 1'b0;
  int         plan_d[$];
  int         plan_l[$];
  logic [3:0] gmask = '0;
  bit         auto_clear = 1'b1;
  int         n_grants = 0;

  // Monitor-side state
  logic [7:0] held_data = '0;
  logic       held_pe = 1'b0, held_pt = 1'b0;
  logic [1:0] held_id = '0;
  int         last_dv = -100;
  bit         rec_order = 1'b0;
  int         order_q[$];
  int         ack_cnt = 0, done_cnt = 0, err_cnt = 0, ack3_cnt = 0;

  task automatic commit();
    int g, d, l;
    ev_t e, e2;
    logic [3:0] oh;
    tx_busy = ((cyc >= busy_lo) && (cyc <= busy_hi)) || ext_busy;
    gmask = '0;
    if (!RST && cyc >= free_at && req != '0 && !tx_busy) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && ((req >> i) & 4'd1) != 4'd0) g = i;
      end
      if (plan_d.size() > 0) d = plan_d.pop_front();
      else d = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(ST-1, 1));
      if (plan_l.size() > 0) l = plan_l.pop_front();
      else l = int'($urandom_range(6, 1));
      oh = 4'b0001 << g;
      e.cyc = cyc + 1; e.vec = {oh, 4'b0000, 1'b0}; e.id = g;
      e.data = req_data[8*g +: 8];
      e.pe = req_par_en[g]; e.pt = req_par_type[g];
      exp_q.push_back(e);
      e2 = e;
      if (d == 0) begin
        e2.cyc = cyc + 1 + ST; e2.vec = {4'b0000, 4'b0000, 1'b1};
        busy_lo = -1; busy_hi = -2;
      end else begin
        busy_lo = cyc + 1 + d;
        busy_hi = busy_lo + l - 1;
        e2.cyc = busy_hi + 2; e2.vec = {4'b0000, oh, 1'b0};
      end
      exp_q.push_back(e2);
      free_at = e2.cyc;
      m_ptr = (g + 1) % NREQ;
      gmask = oh;
      n_grants++;
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
    if (auto_clear) req = req & ~gmask;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      nxt();
      commit();
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] b, input logic pe, input logic pt);
    req_data[8*i +: 8] = b;
    req_par_en[i] = pe;
    req_par_type[i] = pt;
    req[i] = 1'b1;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_ack",  32'(ack), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err",  32'(start_err), 32'(0));
    chk("rst_dv",   32'(Data_Valid), 32'(0));
    chk("rst_data", 32'({active_id, parity_enable, parity_type, P_DATA}), 32'(0));
    exp_q.delete();
    plan_d.delete(); plan_l.delete();
    m_ptr = 0; busy_lo = -1; busy_hi = -2; ext_busy = 1'b0; tx_busy = 1'b0; gmask = '0;
    held_data = '0; held_pe = 1'b0; held_pt = 1'b0; held_id = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    free_at = cyc;
    commit();
  endtask

  always @(negedge CLK) begin
    ev_t e;
    logic [8:0] v;
    int k;
    if (!RST) begin
      k = cyc;
      v = {ack, done, start_err};
      while (exp_q.size() > 0 && exp_q[0].cyc < k) begin
        chk("missing_event", 32'(0), 32'(exp_q[0].vec));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == k) begin
        e = exp_q.pop_front();
        chk("event_vec", 32'(v), 32'(e.vec));
        if (e.vec[8:5] != 4'b0000) begin
          chk("ack_fields", 32'({Data_Valid, parity_enable, parity_type, active_id, P_DATA}),
              32'({1'b1, e.pe, e.pt, 2'(e.id), e.data}));
          held_data = e.data; held_pe = e.pe; held_pt = e.pt; held_id = 2'(e.id);
          last_dv = k;
        end else if (e.vec[0]) begin
          chk("timeout_latency", 32'(k - last_dv), 32'(ST));
        end else begin
          chk("done_id", 32'(active_id), 32'(e.id));
        end
      end else if (v != 9'd0) begin
        chk("unexpected_event", 32'(v), 32'(0));
      end
      if (ack != 4'b0000) begin
        ack_cnt++;
        if (rec_order)
          for (int i = 0; i < NREQ; i++) if (ack[i]) order_q.push_back(i);
      end
      if (ack[3]) ack3_cnt++;
      if (done != 4'b0000) done_cnt++;
      if (start_err) err_cnt++;
      chk("dv_only_with_ack", 32'(Data_Valid), 32'(ack != 4'b0000));
      chk("hold_stable", 32'({active_id, parity_enable, parity_type, P_DATA}),
          32'({held_id, held_pe, held_pt, held_data}));
    end
  end

  initial begin
    int base, a0, d0, e0;
    int exp_order[5];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;

    do_reset();

    // Single request from requester 2
    nxt();
    set_req(2, 8'hA5, 1'b1, 1'b0);
    plan_d.push_back(1); plan_l.push_back(10);
    commit();
    run(25);
    chk("single_active_id", 32'(active_id), 32'(2));

    // All four requesting continuously
    do_reset();
    auto_clear = 1'b0;
    rec_order = 1'b1;
    base = n_grants;
    nxt();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom), 1'($urandom), 1'($urandom));
    commit();
    repeat (120) begin
      nxt();
      if (n_grants - base >= 5) req = '0;
      commit();
    end
    rec_order = 1'b0;
    auto_clear = 1'b1;
    chk("rr_order_len", 32'(order_q.size()), 32'(5));
    for (int i = 0; i < 5 && i < order_q.size(); i++)
      chk("rr_order", 32'(order_q[i]), 32'(exp_order[i]));

    // busy never rises for the first grant
    a0 = ack_cnt; d0 = done_cnt; e0 = err_cnt;
    plan_d.push_back(0); plan_l.push_back(1);
    plan_d.push_back(2); plan_l.push_back(3);
    nxt();
    set_req(0, 8'h3C, 1'b0, 1'b1);
    set_req(1, 8'hC3, 1'b1, 1'b1);
    commit();
    run(25);
    chk("timeout_errs", 32'(err_cnt - e0), 32'(1));
    chk("timeout_dones", 32'(done_cnt - d0), 32'(1));
    chk("timeout_acks", 32'(ack_cnt - a0), 32'(2));

    // Line busy from elsewhere while IDLE
    a0 = ack_cnt;
    nxt();
    ext_busy = 1'b1;
    set_req(0, 8'h5A, 1'b1, 1'b1);
    commit();
    run(6);
    chk("busy_idle_no_ack", 32'(ack_cnt - a0), 32'(0));
    nxt();
    ext_busy = 1'b0;
    commit();
    run(20);
    chk("busy_idle_ack", 32'(ack_cnt - a0), 32'(1));

    // Reset while a frame is in WAIT_DONE
    nxt();
    set_req(0, 8'h81, 1'b0, 1'b0);
    plan_d.push_back(1); plan_l.push_back(10);
    commit();
    run(5);
    set_req(1, 8'h7E, 1'b1, 1'b0);
    d0 = done_cnt; a0 = ack_cnt;
    do_reset();
    run(20);
    chk("rst_abort_acks", 32'(ack_cnt - a0), 32'(1));
    chk("rst_abort_dones", 32'(done_cnt - d0), 32'(1));

    // Requester 3 drops its request one cycle before its turn
    a0 = ack3_cnt;
    nxt();
    set_req(2, 8'h11, 1'b0, 1'b0);
    set_req(3, 8'h33, 1'b1, 1'b0);
    set_req(0, 8'h00, 1'b1, 1'b1);
    plan_d.push_back(1); plan_l.push_back(6);
    commit();
    repeat (25) begin
      nxt();
      if (cyc == free_at - 1) req[3] = 1'b0;
      commit();
    end
    chk("drop_no_ack3", 32'(ack3_cnt - a0), 32'(0));

    // Randomized traffic
    repeat (800) begin
      nxt();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(3) == 0)
          set_req(i, 8'($urandom), 1'($urandom), 1'($urandom));
        else if (req[i] && $urandom_range(31) == 0)
          req[i] = 1'b0;
      end
      if (cyc >= free_at) begin
        if ($urandom_range(15) == 0) ext_busy = ~ext_busy;
      end else begin
        ext_busy = 1'b0;
      end
      commit();
    end

    nxt();
    req = '0;
    ext_busy = 1'b0;
    commit();
    run(40);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one `UART_TX` instance between `NREQ` independent byte producers. It grants one requester at a time and latches that requester's byte and per-requester parity settings. It then drives the `UART_TX` `Data_Valid`/`P_DATA`/`parity_enable`/`parity_type` inputs, and tracks the frame through `UART_TX`'s `busy` output until the line is free again. It sits directly in front of `UART_TX`; all requesters see only a req/ack/done handshake.

## Interface
- `WIDTH`, default 8 (equals `` `WIDTH ``): data byte width.
- `NREQ`, default 4: number of requesters, 2..8.
- `START_TIMEOUT`, default 4: cycles allowed after `Data_Valid` for `busy` to rise.

Ports:
- `CLK`  in  1  single clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester request; held with data until `ack`.
- `req_data`  in  NREQ*WIDTH  requester i byte at [i*WIDTH +: WIDTH].
- `req_par_en`  in  NREQ  per-requester parity enable.
- `req_par_type`  in  NREQ  per-requester parity type.
- `ack`  out  NREQ  one-hot, 1-cycle pulse: request accepted, data latched.
- `done`  out  NREQ  one-hot, 1-cycle pulse: granted frame fully transmitted.
- `start_err`  out  1  1-cycle pulse: `busy` never rose for the active grant.
- `active_id`  out  clog2(NREQ)  index of the current or most recent grantee.
- `tx_busy`  in  1  from `UART_TX` `busy`.
- `Data_Valid`  out  1  to `UART_TX`.
- `P_DATA`  out  WIDTH  to `UART_TX`.
- `parity_enable`  out  1  to `UART_TX`.
- `parity_type`  out  1  to `UART_TX`.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets state to IDLE and the round-robin pointer `ptr` to 0.
- States are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
- **IDLE:** when `|req` and `tx_busy==0`, select the first set `req` bit searching from `ptr` upward with wrap-around.
  - At that edge: latch data and parity into `P_DATA`/`parity_enable`/`parity_type`, set `active_id`, pulse `ack[g]`, set `Data_Valid`, set `ptr <= (g+1) mod NREQ`, and go to ISSUE.
  - If `tx_busy==1` in IDLE (the line is owned elsewhere or a frame is still draining), no grant is made.
- **ISSUE:** `Data_Valid=1` for exactly this one cycle. Next state is WAIT_BUSY with the timeout counter cleared.
- **WAIT_BUSY:**
  - If `tx_busy==1`, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `START_TIMEOUT-1` without `busy`, pulse `start_err`, return to IDLE, and do not pulse `done`.
- **WAIT_DONE:** on the first cycle with `tx_busy==0`, pulse `done[active_id]` and return to IDLE.
- `P_DATA`, `parity_enable`, `parity_type` and `active_id` are held stable from the grant until the next grant, never changing mid-frame.
- A requester that drops `req` before `ack` is simply not granted; no error is raised.
- `req` of the current grantee is ignored until the scheduler is back in IDLE.
- Requests arriving during a frame wait. The grant order after each frame is round-robin from `ptr`, so no requester starves while others are requesting.
- Reset mid-frame (`RST` is shared with `UART_TX`): `Data_Valid`, `ack`, `done` and `start_err` drop immediately. No completion is reported for the aborted frame.

## Timing
- Grant latency: `req` seen in IDLE at cycle N; `ack` and `Data_Valid` are high in cycle N+1.
- `Data_Valid` is never high for more than one cycle and is never high while in IDLE, WAIT_BUSY or WAIT_DONE.
- `busy` rise is tolerated 1 to `START_TIMEOUT-1` cycles after the `Data_Valid` cycle.
- `done` is high the cycle after the first `tx_busy==0` sample in WAIT_DONE.
- Back-to-back frames: the `done` cycle is spent in IDLE. The next `Data_Valid` comes 1 cycle after `done` when any `req` is pending, giving a 1-cycle minimum idle gap between frames.
- `ack`, `done` and `start_err` are mutually exclusive in any cycle.

## Test plan
- **Single request.** `RST` pulse, then `req=4'b0100` with `req_data[2]=8'hA5`, par_en=1, type=0, and a `busy` model that rises 1 cycle after `Data_Valid` and stays high 10 cycles.
  - Required: `ack=4'b0100` and `Data_Valid=1`, `P_DATA=8'hA5`, `parity_enable=1`, `parity_type=0` in the same cycle; `done=4'b0100` 1 cycle after `busy` falls; `active_id=2`.
- **All four request continuously.**
  - Required: grant order 0,1,2,3,0; exactly one `ack` per frame; `P_DATA` never changes while `tx_busy=1`.
- **`busy` tied 0.**
  - Required: `start_err` pulses exactly `START_TIMEOUT` cycles after the `Data_Valid` cycle; no `done`; the next requester is granted afterwards.
- **`tx_busy=1` held in IDLE with `req=4'b0001`.**
  - Required: no `ack` until `busy` drops; then `ack=4'b0001` 1 cycle later.
- **`RST` asserted in WAIT_DONE.**
  - Required: all outputs go to 0 asynchronously; after release, a pending `req=4'b0010` is granted from `ptr=0` with no `done` for the aborted frame.
- **Requester 3 drops `req` one cycle before its turn.**
  - Required: it is skipped and the grant goes to the next set bit, with no `ack[3]`.
